// File: rtl/prim_fifo_async_wr_arb_pkg.sv
// prim_fifo_async_arb_pkg: shared FSM state type and round-robin pick helper for FIFO write arbiters
// Contents: arb_state_e (IDLE/LOCK), rr_res_t (found flag + index), rr_pick(valid, ptr, n).
package prim_fifo_async_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned MaxReq = 32;
    localparam int unsigned PtrW   = $clog2(MaxReq);

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } rr_res_t;

    // First set bit of valid at or above ptr, wrapping at n (n need not be a power of two).
    function automatic rr_res_t rr_pick(input logic [MaxReq-1:0] valid, input int unsigned ptr,
                                        input int unsigned n);
        rr_res_t     res;
        int unsigned j;
        res = '0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if (k < n && !res.found && valid[j[PtrW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = j;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_rr_pick.sv
// prim_rr_pick: combinational round-robin priority picker
// Ports: valid_i (request vector), ptr_i (highest-priority index),
//        idx_o (chosen index), found_o (any request present).
module prim_rr_pick
    import prim_fifo_async_arb_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    rr_res_t res;

    always_comb begin
        res     = rr_pick(MaxReq'(valid_i), 32'(ptr_i), N);
        found_o = res.found;
        idx_o   = '0;
        for (int i = 0; i < N; i++) idx_o = (res.idx == 32'(i)) ? IdxW'(i) : idx_o;
    end

endmodule

// File: rtl/prim_fifo_async_wr_arb.sv
// prim_fifo_async_wr_arb: packet-atomic round-robin arbiter sharing one async FIFO write port
// Ports: clk_wr_i/rst_wr_ni (write clock, async active-low reset);
//        req_valid_i/req_last_i/req_data_i/req_ready_o (N requesters, data packed Width each);
//        fifo_wvalid_o/fifo_wready_i/fifo_wdata_o (FIFO write port);
//        gnt_idx_o/gnt_valid_o (current owner).
// Option: PRIM_FIFO_ASYNC_WR_ARB_STATS_EN adds beat_cnt_o, a 16-bit saturating beat count per requester.
module prim_fifo_async_wr_arb
    import prim_fifo_async_arb_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned Width    = 16,
    parameter  int unsigned MaxBurst = 8,
    localparam int unsigned IdxW     = $clog2(N),
    localparam int unsigned CntW     = $clog2(MaxBurst + 1)
) (
    input  logic               clk_wr_i,
    input  logic               rst_wr_ni,
    input  logic [N-1:0]       req_valid_i,
    input  logic [N-1:0]       req_last_i,
    input  logic [N*Width-1:0] req_data_i,
    output logic [N-1:0]       req_ready_o,
    output logic               fifo_wvalid_o,
    input  logic               fifo_wready_i,
    output logic [Width-1:0]   fifo_wdata_o,
    output logic [IdxW-1:0]    gnt_idx_o,
    output logic               gnt_valid_o
`ifdef PRIM_FIFO_ASYNC_WR_ARB_STATS_EN
    ,
    output logic [N*16-1:0]    beat_cnt_o
`endif
);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, pick_idx;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pick_found, lock, own_valid, own_last, beat, rel;

    prim_rr_pick #(.N(N)) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Owner mux built from constant selects so non-power-of-two N never indexes out of range.
    always_comb begin
        own_valid    = 1'b0;
        own_last     = 1'b0;
        fifo_wdata_o = '0;
        for (int i = 0; i < N; i++) begin
            own_valid    = (gnt_q == IdxW'(i)) ? req_valid_i[i] : own_valid;
            own_last     = (gnt_q == IdxW'(i)) ? req_last_i[i] : own_last;
            fifo_wdata_o = (gnt_q == IdxW'(i)) ? req_data_i[i*Width +: Width] : fifo_wdata_o;
        end
    end

    assign lock          = state_q == LOCK;
    assign gnt_valid_o   = lock;
    assign gnt_idx_o     = gnt_q;
    assign fifo_wvalid_o = lock & own_valid;
    // Ready depends only on the grant and wready, never on any requester's valid.
    assign req_ready_o   = lock ? (N'(fifo_wready_i) << gnt_q) : '0;
    assign beat          = fifo_wvalid_o & fifo_wready_i;
    assign rel           = beat & (own_last | (cnt_q == CntW'(MaxBurst - 1)));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (!lock) begin
            if (pick_found) begin
                state_d = LOCK;
                gnt_d   = pick_idx;
                cnt_d   = '0;
            end
        end else if (rel) begin
            state_d = IDLE;
            ptr_d   = (gnt_q == IdxW'(N - 1)) ? '0 : gnt_q + 1'b1;
            cnt_d   = '0;
        end else if (beat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
        if (!rst_wr_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PRIM_FIFO_ASYNC_WR_ARB_STATS_EN
    for (genvar i = 0; i < N; i++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk_wr_i or negedge rst_wr_ni) begin
            if (!rst_wr_ni) cnt <= '0;
            else if (beat && gnt_q == IdxW'(i) && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
        end
        assign beat_cnt_o[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_prim_fifo_async_wr_arb.sv
// tb_prim_fifo_async_wr_arb: directed scoreboard bench for the FIFO write arbiter
module tb_prim_fifo_async_wr_arb;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk_wr_i  = 1'b0;
    logic           rst_wr_ni = 1'b0;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
    logic [N*W-1:0] req_data  = '0;
    logic           fifo_wvalid, fifo_wready = 1'b0, gnt_valid;
    logic [W-1:0]   fifo_wdata;
    logic [1:0]     gnt_idx;
`ifdef PRIM_FIFO_ASYNC_WR_ARB_STATS_EN
    logic [N*16-1:0] beat_cnt;
`endif

    logic [16:0]  src_q [N][$];
    logic [17:0]  exp_q [$];
    logic [17:0]  exp_item;
    int           beat_cyc [$];
    int           nbeat [N];
    logic [N-1:0] hold = '0, fired = '0;
    logic         wr_en = 1'b1;
    int           cyc = 0, checks = 0, errors = 0;

    prim_fifo_async_wr_arb #(.N(N), .Width(W), .MaxBurst(8)) dut (
        .clk_wr_i      (clk_wr_i),
        .rst_wr_ni     (rst_wr_ni),
        .req_valid_i   (req_valid),
        .req_last_i    (req_last),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .fifo_wvalid_o (fifo_wvalid),
        .fifo_wready_i (fifo_wready),
        .fifo_wdata_o  (fifo_wdata),
        .gnt_idx_o     (gnt_idx),
        .gnt_valid_o   (gnt_valid)
`ifdef PRIM_FIFO_ASYNC_WR_ARB_STATS_EN
        ,
        .beat_cnt_o    (beat_cnt)
`endif
    );

    always #5 clk_wr_i = ~clk_wr_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_wr_i);
        #2;
    endtask

    task automatic src(input int i, input logic last, input logic [15:0] d);
        src_q[i].push_back({last, d});
    endtask

    task automatic expb(input int i, input logic [15:0] d);
        exp_q.push_back({2'(i), d});
    endtask

    function automatic logic busy();
        busy = exp_q.size() != 0;
        for (int i = 0; i < N; i++) busy = busy | (src_q[i].size() != 0);
    endfunction

    task automatic drain(input string tag);
        for (int n = 0; n < 400 && busy(); n++) step(1);
        step(2);
        chk(tag, {31'b0, busy()}, 32'd0);
    endtask

    task automatic wait_beats(input int k);
        for (int n = 0; n < 100 && beat_cyc.size() < k; n++) step(1);
        chk("wait_beats", {31'b0, beat_cyc.size() >= k}, 32'd1);
    endtask

    task automatic clear_stats();
        beat_cyc.delete();
        for (int i = 0; i < N; i++) nbeat[i] = 0;
    endtask

    // Source BFM and FIFO-side scoreboard: inputs change on the falling edge, the bus is
    // sampled 1 ns later, and beats that handshook are retired at the next falling edge.
    always @(negedge clk_wr_i) begin
        cyc++;
        for (int i = 0; i < N; i++) if (fired[i]) void'(src_q[i].pop_front());
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = src_q[i].size() != 0 && !hold[i];
            req_last[i]          = req_valid[i] ? src_q[i][0][16] : 1'b0;
            req_data[i*W +: W]   = req_valid[i] ? src_q[i][0][15:0] : 16'h0;
        end
        fifo_wready = wr_en;
        #1;
        if (fifo_wvalid && fifo_wready) begin
            beat_cyc.push_back(cyc);
            nbeat[gnt_idx]++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 32'({gnt_idx, fifo_wdata}), 32'h3FFFF);
            end else begin
                exp_item = exp_q.pop_front();
                chk("beat", 32'({gnt_idx, fifo_wdata}), 32'(exp_item));
            end
        end
        fired = req_valid & req_ready;
    end

    initial begin
        step(2);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wvalid", 32'(fifo_wvalid), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        rst_wr_ni = 1'b1;
        step(2);

        // single requester, 3-beat packet
        src(2, 1'b0, 16'hA0A0); src(2, 1'b0, 16'hB0B0); src(2, 1'b1, 16'hC0C0);
        expb(2, 16'hA0A0); expb(2, 16'hB0B0); expb(2, 16'hC0C0);
        clear_stats();
        step(1);
        chk("t1_idle_cycle", 32'(gnt_valid), 32'd0);
        step(1);
        chk("t1_gnt_valid", 32'(gnt_valid), 32'd1);
        chk("t1_gnt_idx", 32'(gnt_idx), 32'd2);
        drain("t1_drain");
        chk("t1_consecutive", 32'(beat_cyc[2] - beat_cyc[0]), 32'd2);

        // fairness: all valid, 1-beat packets; pointer left at 3 by the previous packet
        clear_stats();
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 4; k++) expb((3 + k) % 4, 16'(32'h2000 + ((3 + k) % 4) * 16 + r));
        for (int i = 0; i < N; i++)
            for (int r = 0; r < 5; r++) src(i, 1'b1, 16'(32'h2000 + i * 16 + r));
        drain("t2_drain");
        for (int i = 0; i < N; i++) chk("t2_share", 32'(nbeat[i]), 32'd5);
        chk("t2_span", 32'(beat_cyc[19] - beat_cyc[0]), 32'd38);
        step(3);
        chk("idle_hold", 32'(gnt_valid), 32'd0);

        // forced release after 8 beats
        clear_stats();
        src(3, 1'b1, 16'h33A0); src(3, 1'b1, 16'h33A1);
        for (int k = 0; k < 12; k++) src(1, k == 11, 16'(32'h1100 + k));
        expb(3, 16'h33A0);
        for (int k = 0; k < 8; k++) expb(1, 16'(32'h1100 + k));
        expb(3, 16'h33A1);
        for (int k = 8; k < 12; k++) expb(1, 16'(32'h1100 + k));
        drain("t3_drain");
        chk("t3_burst_rate", 32'(beat_cyc[8] - beat_cyc[1]), 32'd7);

        // backpressure for 5 cycles after two beats of a 10-beat packet
        clear_stats();
        for (int k = 0; k < 10; k++) begin
            src(0, k == 9, 16'(32'h4000 + k));
            expb(0, 16'(32'h4000 + k));
        end
        wait_beats(2);
        wr_en = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step(1);
            chk("t4_ready_low", 32'(req_ready), 32'd0);
            chk("t4_wdata_stable", 32'(fifo_wdata), 32'h4002);
            chk("t4_wvalid_held", 32'(fifo_wvalid), 32'd1);
        end
        wr_en = 1'b1;
        drain("t4_drain");
        chk("t4_stall_gap", 32'(beat_cyc[2] - beat_cyc[1]), 32'd6);
        chk("t4_no_early_release", 32'(beat_cyc[7] - beat_cyc[2]), 32'd5);
        chk("t4_release_after_8", 32'(beat_cyc[8] - beat_cyc[7]), 32'd2);

        // owner gap: owner 0 pauses while 1 waits
        clear_stats();
        for (int k = 0; k < 4; k++) begin
            src(0, k == 3, 16'(32'h5000 + k));
            expb(0, 16'(32'h5000 + k));
        end
        expb(1, 16'h5100);
        wait_beats(2);
        hold[0] = 1'b1;
        src(1, 1'b1, 16'h5100);
        for (int s = 0; s < 4; s++) begin
            step(1);
            chk("t5_gnt_valid", 32'(gnt_valid), 32'd1);
            chk("t5_gnt_idx", 32'(gnt_idx), 32'd0);
            chk("t5_ready1_low", 32'(req_ready[1]), 32'd0);
            chk("t5_wvalid_low", 32'(fifo_wvalid), 32'd0);
        end
        hold[0] = 1'b0;
        drain("t5_drain");

        // reset in mid-packet: partial packet stays written, pointer restarts at 0
        clear_stats();
        for (int k = 0; k < 6; k++) src(2, k == 5, 16'(32'h6000 + k));
        expb(2, 16'h6000); expb(2, 16'h6001); expb(0, 16'h6A00);
        for (int k = 2; k < 6; k++) expb(2, 16'(32'h6000 + k));
        wait_beats(2);
        @(posedge clk_wr_i);
        #1;
        rst_wr_ni = 1'b0;
        #1;
        chk("t6_rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_rst_wvalid", 32'(fifo_wvalid), 32'd0);
        chk("t6_rst_gnt_idx", 32'(gnt_idx), 32'd0);
        src(0, 1'b1, 16'h6A00);
        step(2);
        chk("t6_in_rst", 32'(gnt_valid), 32'd0);
        rst_wr_ni = 1'b1;
        step(1);
        chk("t6_first_gnt_valid", 32'(gnt_valid), 32'd1);
        chk("t6_first_gnt_idx", 32'(gnt_idx), 32'd0);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
